per2axi_req_arbiter: RTL and testbench
======================================

# per2axi_req_arbiter

Round-robin arbiter and credit controller that shares one per2axi peripheral request port between NB_REQ peripheral-interconnect requesters. It sits directly upstream of the per2axi request channel. It keeps the selected request stable until the downstream port grants it, which preserves AXI valid stability. It also limits outstanding AXI reads and writes with two credit counters, so the response path never overflows.

## Interface
- NB_REQ, 4, number of requesters (≥2)
- PER_ADDR_WIDTH, 32, address width
- PER_ID_WIDTH, 5, one-hot transaction ID width
- MAX_RD_OUTSTANDING, 4, read credit limit (≥1)
- MAX_WR_OUTSTANDING, 4, write credit limit (≥1)
- clk_i  in  1  clock, one clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  NB_REQ  per-requester request
- add_i  in  NB_REQ×PER_ADDR_WIDTH  per-requester address
- we_i  in  NB_REQ  per-requester direction: 1 = read, 0 = write (per-interconnect convention)
- atop_i  in  NB_REQ×6  per-requester atomic opcode
- wdata_i  in  NB_REQ×32  per-requester write data
- be_i  in  NB_REQ×4  per-requester byte enables
- id_i  in  NB_REQ×PER_ID_WIDTH  per-requester one-hot ID
- gnt_o  out  NB_REQ  one-hot grant
- per_master_req_o / add_o / we_o / atop_o / wdata_o / be_o / id_o  out  matching widths  muxed request to the request channel
- per_master_gnt_i  in  1  downstream grant
- rd_done_i  in  1  one read response retired (R handshake)
- wr_done_i  in  1  one write response retired (B handshake)
- flush_i  in  1  block new arbitration
- idle_o  out  1  no held request and no outstanding transactions
- rd_cnt_o  out  $clog2(MAX_RD_OUTSTANDING+1)  outstanding reads
- wr_cnt_o  out  $clog2(MAX_WR_OUTSTANDING+1)  outstanding writes
- cnt_err_o  out  1  sticky: a done pulse arrived while its counter was 0

## Operation
- Eligibility:
  - requester i is eligible when req_i[i]=1 and its direction has credit: reads need rd_cnt<MAX_RD_OUTSTANDING, writes need wr_cnt<MAX_WR_OUTSTANDING.
  - flush_i=1 makes no requester eligible.
- The FSM has two states, IDLE and HOLD.
- IDLE:
  - The winner is the first eligible index at or after rr_ptr, searching upward with wrap.
  - per_master_* carries the winner's payload and per_master_req_o=1.
  - If per_master_gnt_i=1, then gnt_o[winner]=1 and rr_ptr ← (winner+1) mod NB_REQ. The FSM stays in IDLE.
  - If per_master_gnt_i=0, then sel ← winner and the FSM moves to HOLD.
  - With no eligible requester, per_master_req_o=0 and the payload outputs are 0.
- HOLD:
  - per_master_* is driven from requester sel. No re-arbitration, credit check or flush masking applies.
  - If per_master_gnt_i=1, then gnt_o[sel]=1, rr_ptr ← sel+1 and the FSM moves to IDLE.
  - If req_i[sel] drops (protocol violation), per_master_req_o=0, no grant is issued, rr_ptr is unchanged and the FSM moves to IDLE.
- Credits:
  - A granted read increments rd_cnt; rd_done_i decrements it. The same rules apply to writes with wr_cnt and wr_done_i.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - A decrement at 0 leaves the counter at 0 and sets cnt_err_o.
  - Counters never exceed their MAX, because credit is checked before selection and HOLD holds at most one request.
- idle_o = (state==IDLE) && rd_cnt==0 && wr_cnt==0.

## Timing
- Reset (async assert): state=IDLE, rr_ptr=0, sel=0, rd_cnt=0, wr_cnt=0, cnt_err_o=0. Combinational outputs follow from these: gnt_o=0, per_master_req_o=0 and idle_o=1 whatever req_i is.
- Reset assertion mid-HOLD drops the held request immediately, with no grant issued.
- IDLE grant latency is 0 cycles. The req→gnt path is combinational through the arbiter when per_master_gnt_i is high.
- HOLD adds no latency: the grant is issued in the cycle per_master_gnt_i rises.
- Counters and the pointer update on the clk_i rising edge after a handshake. A credit freed by rd_done_i in cycle N is usable in cycle N+1.
- Payload outputs are stable for every cycle that per_master_req_o is high without a grant.
- gnt_o is at most one-hot and is never asserted without per_master_gnt_i.

## Test plan
- All 4 requesters issue reads, per_master_gnt_i=1 constantly, MAX_RD=8, rd_done_i=0 → grants go to 0,1,2,3,0 on consecutive cycles and rd_cnt reaches 5.
- Requester 2 writes while per_master_gnt_i=0 for 3 cycles, and requester 1 asserts a read in cycle 1 → the output stays on requester 2 with stable payload, gnt_o=4'b0100 in cycle 3, then requester 1 is granted.
- MAX_RD=2 with two reads granted, requester 0 reading and requester 3 writing → only requester 3 is granted. A rd_done_i pulse lets requester 0 be granted the next cycle.
- Read granted in the same cycle as a rd_done_i pulse with rd_cnt=1 → rd_cnt stays 1. rd_done_i at rd_cnt=0 → cnt_err_o=1 until reset.
- flush_i=1 with requesters pending and rd_cnt=1 → no grants. After rd_done_i, idle_o=1.
- rst_ni asserted while in HOLD → per_master_req_o=0, gnt_o=0 and idle_o=1 immediately. After release, arbitration starts at requester 0.

Source files
------------

// File: rtl/per2axi_req_arbiter.sv
// rtl/per2axi_req_arbiter.sv - round-robin request arbiter with read/write credit limiting for per2axi
module per2axi_req_arbiter #(
  parameter int NB_REQ             = 4,
  parameter int PER_ADDR_WIDTH     = 32,
  parameter int PER_ID_WIDTH       = 5,
  parameter int MAX_RD_OUTSTANDING = 4,
  parameter int MAX_WR_OUTSTANDING = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NB_REQ-1:0]                          req_i,
  input  logic [NB_REQ*PER_ADDR_WIDTH-1:0]           add_i,
  input  logic [NB_REQ-1:0]                          we_i,
  input  logic [NB_REQ*6-1:0]                        atop_i,
  input  logic [NB_REQ*32-1:0]                       wdata_i,
  input  logic [NB_REQ*4-1:0]                        be_i,
  input  logic [NB_REQ*PER_ID_WIDTH-1:0]             id_i,
  output logic [NB_REQ-1:0]                          gnt_o,
  output logic                                       per_master_req_o,
  output logic [PER_ADDR_WIDTH-1:0]                  per_master_add_o,
  output logic                                       per_master_we_o,
  output logic [5:0]                                 per_master_atop_o,
  output logic [31:0]                                per_master_wdata_o,
  output logic [3:0]                                 per_master_be_o,
  output logic [PER_ID_WIDTH-1:0]                    per_master_id_o,
  input  logic                                       per_master_gnt_i,
  input  logic                                       rd_done_i,
  input  logic                                       wr_done_i,
  input  logic                                       flush_i,
  output logic                                       idle_o,
  output logic [$clog2(MAX_RD_OUTSTANDING+1)-1:0]    rd_cnt_o,
  output logic [$clog2(MAX_WR_OUTSTANDING+1)-1:0]    wr_cnt_o,
  output logic                                       cnt_err_o
);

  localparam int IDXW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int RCW  = $clog2(MAX_RD_OUTSTANDING+1);
  localparam int WCW  = $clog2(MAX_WR_OUTSTANDING+1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_rr_ptr;
  logic [IDXW-1:0]   r_sel;
  logic [RCW-1:0]    r_rd_cnt;
  logic [WCW-1:0]    r_wr_cnt;
  logic              r_cnt_err;

  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [NB_REQ-1:0] w_elig;
  logic              w_any;
  logic [IDXW-1:0]   w_winner;
  logic [IDXW-1:0]   w_src;
  logic [IDXW-1:0]   w_src_nxt;
  logic              w_req;
  logic              w_hs;
  logic              w_rd_inc;
  logic              w_wr_inc;

  assign w_rd_ok = r_rd_cnt < RCW'(MAX_RD_OUTSTANDING);
  assign w_wr_ok = r_wr_cnt < WCW'(MAX_WR_OUTSTANDING);
  assign w_elig  = flush_i ? '0 :
                   req_i & ((we_i & {NB_REQ{w_rd_ok}}) | (~we_i & {NB_REQ{w_wr_ok}}));

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx      = 0;
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = NB_REQ-1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      if (w_elig[idx]) begin
        w_any    = 1'b1;
        w_winner = IDXW'(idx);
      end
    end
  end

  // Reset gating keeps the port quiet while rst_ni is low, even with requests pending.
  assign w_src     = (r_state == HOLD) ? r_sel : w_winner;
  assign w_req     = rst_ni && ((r_state == HOLD) ? req_i[r_sel] : w_any);
  assign w_hs      = w_req && per_master_gnt_i;
  assign w_rd_inc  = w_hs && we_i[w_src];
  assign w_wr_inc  = w_hs && !we_i[w_src];
  assign w_src_nxt = (w_src == IDXW'(NB_REQ-1)) ? '0 : w_src + 1'b1;

  assign per_master_req_o = w_req;
  assign gnt_o            = w_hs ? (NB_REQ'(1) << w_src) : '0;

  always_comb begin
    per_master_add_o   = '0;
    per_master_we_o    = 1'b0;
    per_master_atop_o  = '0;
    per_master_wdata_o = '0;
    per_master_be_o    = '0;
    per_master_id_o    = '0;
    if (w_req) begin
      per_master_add_o   = add_i[int'(w_src)*PER_ADDR_WIDTH +: PER_ADDR_WIDTH];
      per_master_we_o    = we_i[w_src];
      per_master_atop_o  = atop_i[int'(w_src)*6 +: 6];
      per_master_wdata_o = wdata_i[int'(w_src)*32 +: 32];
      per_master_be_o    = be_i[int'(w_src)*4 +: 4];
      per_master_id_o    = id_i[int'(w_src)*PER_ID_WIDTH +: PER_ID_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_sel     <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_cnt_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_rr_ptr <= w_src_nxt;
          end else if (w_any) begin
            r_sel   <= w_winner;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          // A dropped request abandons the hold without touching the pointer.
          if (!req_i[r_sel]) begin
            r_state <= IDLE;
          end else if (per_master_gnt_i) begin
            r_rr_ptr <= w_src_nxt;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_rd_inc && !rd_done_i)
        r_rd_cnt <= r_rd_cnt + 1'b1;
      else if (rd_done_i && !w_rd_inc && (r_rd_cnt != '0))
        r_rd_cnt <= r_rd_cnt - 1'b1;

      if (w_wr_inc && !wr_done_i)
        r_wr_cnt <= r_wr_cnt + 1'b1;
      else if (wr_done_i && !w_wr_inc && (r_wr_cnt != '0))
        r_wr_cnt <= r_wr_cnt - 1'b1;

      if ((rd_done_i && (r_rd_cnt == '0)) || (wr_done_i && (r_wr_cnt == '0)))
        r_cnt_err <= 1'b1;
    end
  end

  assign idle_o    = (r_state == IDLE) && (r_rd_cnt == '0) && (r_wr_cnt == '0);
  assign rd_cnt_o  = r_rd_cnt;
  assign wr_cnt_o  = r_wr_cnt;
  assign cnt_err_o = r_cnt_err;

endmodule

// File: tb/tb_per2axi_req_arbiter.sv
// tb/tb_per2axi_req_arbiter.sv - directed self-checking bench for per2axi_req_arbiter
module tb_per2axi_req_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req, we, gnt;
  logic [127:0] add;
  logic [23:0]  atop;
  logic [127:0] wdata;
  logic [15:0]  be;
  logic [19:0]  id;
  logic         m_req, m_we, m_gnt;
  logic [31:0]  m_add, m_wdata;
  logic [5:0]   m_atop;
  logic [3:0]   m_be;
  logic [4:0]   m_id;
  logic         rd_done, wr_done, flush, idle, cnt_err;
  logic [3:0]   rd_cnt;
  logic [2:0]   wr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  per2axi_req_arbiter #(
    .NB_REQ(4), .PER_ADDR_WIDTH(32), .PER_ID_WIDTH(5),
    .MAX_RD_OUTSTANDING(8), .MAX_WR_OUTSTANDING(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .we_i(we),
    .atop_i(atop), .wdata_i(wdata), .be_i(be), .id_i(id), .gnt_o(gnt),
    .per_master_req_o(m_req), .per_master_add_o(m_add), .per_master_we_o(m_we),
    .per_master_atop_o(m_atop), .per_master_wdata_o(m_wdata), .per_master_be_o(m_be),
    .per_master_id_o(m_id), .per_master_gnt_i(m_gnt), .rd_done_i(rd_done),
    .wr_done_i(wr_done), .flush_i(flush), .idle_o(idle), .rd_cnt_o(rd_cnt),
    .wr_cnt_o(wr_cnt), .cnt_err_o(cnt_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      add[i*32 +: 32]   = 32'hA000_0000 + 32'(i*16);
      atop[i*6 +: 6]    = 6'(i + 8);
      wdata[i*32 +: 32] = 32'hD000_0000 + 32'(i);
      be[i*4 +: 4]      = 4'b0001 << i;
      id[i*5 +: 5]      = 5'b00001 << i;
    end
    rst_n = 1'b0; req = 4'hF; we = 4'hF; m_gnt = 1'b1;
    rd_done = 1'b0; wr_done = 1'b0; flush = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_req", 64'(m_req), 64'h0);
    chk("rst_idle", 64'(idle), 64'h1);
    chk("rst_add", 64'(m_add), 64'h0);
    tick();

    // Round robin with constant downstream grant
    rst_n = 1'b1; #1;
    for (int g = 0; g < 5; g++) begin
      chk("rr_gnt", 64'(gnt), 64'(4'b0001 << (g % 4)));
      tick();
    end
    chk("rr_rdcnt", 64'(rd_cnt), 64'd5);

    // Hold on requester 2 (write) with grant withheld
    req = 4'b0100; we = 4'b1011; m_gnt = 1'b0; #1;
    chk("hold_req", 64'(m_req), 64'h1);
    chk("hold_add0", 64'(m_add), 64'hA000_0020);
    chk("hold_gnt0", 64'(gnt), 64'h0);
    tick();
    req = 4'b0110; #1;
    chk("hold_add1", 64'(m_add), 64'hA000_0020);
    chk("hold_we1", 64'(m_we), 64'h0);
    tick();
    chk("hold_id2", 64'(m_id), 64'h04);
    chk("hold_wdata2", 64'(m_wdata), 64'hD000_0002);
    tick();
    m_gnt = 1'b1; #1;
    chk("hold_gnt3", 64'(gnt), 64'b0100);
    chk("hold_be3", 64'(m_be), 64'b0100);
    tick();
    chk("after_hold_gnt", 64'(gnt), 64'b0010);
    chk("after_hold_atop", 64'(m_atop), 64'd9);
    tick();
    req = 4'b0000; #1;
    chk("cnt_rd6", 64'(rd_cnt), 64'd6);
    chk("cnt_wr1", 64'(wr_cnt), 64'd1);

    // Fill read credit, then only the writer may win
    req = 4'b0001; we = 4'b1111;
    tick(); tick();
    chk("cnt_rd8", 64'(rd_cnt), 64'd8);
    req = 4'b1001; we = 4'b0111; #1;
    chk("credit_gnt_wr", 64'(gnt), 64'b1000);
    tick();
    req = 4'b0001; rd_done = 1'b1; #1;
    chk("credit_blocked", 64'(gnt), 64'h0);
    chk("credit_blocked_req", 64'(m_req), 64'h0);
    tick();
    rd_done = 1'b0; #1;
    chk("credit_freed_gnt", 64'(gnt), 64'b0001);
    tick();
    chk("credit_rd8b", 64'(rd_cnt), 64'd8);
    chk("credit_wr2", 64'(wr_cnt), 64'd2);

    // Drain to rd_cnt=1, then grant and retire in the same cycle
    req = 4'b0000; rd_done = 1'b1;
    repeat (7) tick();
    rd_done = 1'b0; #1;
    chk("drain_rd1", 64'(rd_cnt), 64'd1);
    req = 4'b0001; rd_done = 1'b1; #1;
    chk("incdec_gnt", 64'(gnt), 64'b0001);
    tick();
    req = 4'b0000; #1;
    chk("incdec_rd1", 64'(rd_cnt), 64'd1);
    tick();
    rd_done = 1'b0; wr_done = 1'b1;
    tick(); tick();
    wr_done = 1'b0; #1;
    chk("drained_rd0", 64'(rd_cnt), 64'd0);
    chk("drained_wr0", 64'(wr_cnt), 64'd0);
    chk("no_err_yet", 64'(cnt_err), 64'h0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0; #1;
    chk("err_set", 64'(cnt_err), 64'h1);
    chk("err_rd0", 64'(rd_cnt), 64'd0);
    tick();
    chk("err_sticky", 64'(cnt_err), 64'h1);

    // Flush blocks arbitration
    req = 4'b0001;
    tick();
    flush = 1'b1; req = 4'hF; we = 4'hF; #1;
    chk("flush_gnt", 64'(gnt), 64'h0);
    chk("flush_req", 64'(m_req), 64'h0);
    chk("flush_idle0", 64'(idle), 64'h0);
    tick();
    chk("flush_rd1", 64'(rd_cnt), 64'd1);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0; #1;
    chk("flush_idle1", 64'(idle), 64'h1);
    flush = 1'b0; req = 4'b0000;

    // Reset while holding
    m_gnt = 1'b0; req = 4'b0100; we = 4'b0000;
    tick();
    chk("hold_pre_rst", 64'(m_req), 64'h1);
    chk("hold_pre_idle", 64'(idle), 64'h0);
    rst_n = 1'b0; m_gnt = 1'b1; #1;
    chk("rst_hold_req", 64'(m_req), 64'h0);
    chk("rst_hold_gnt", 64'(gnt), 64'h0);
    chk("rst_hold_idle", 64'(idle), 64'h1);
    chk("rst_err_clr", 64'(cnt_err), 64'h0);
    tick();
    rst_n = 1'b1; req = 4'hF; we = 4'hF; #1;
    chk("post_rst_gnt", 64'(gnt), 64'b0001);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
